// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace capture block.
//   - state_e   : capture FSM encoding (IDLE=0, ARMED=1, RUN=2, DONE=3)
//   - W_*       : word index of each field inside a 4-word record
//   - FLAG_*    : bit positions of the branch/zero flags in the flags word
//   - rec_t     : one 128-bit commit record as stored in the FIFO
//   - pack_flags: builds the flags word {branch, zero, 25'b0, dest}
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] W_PC    = 2'd0;
  localparam logic [1:0] W_INSTR = 2'd1;
  localparam logic [1:0] W_ALU   = 2'd2;
  localparam logic [1:0] W_FLAGS = 2'd3;

  localparam int FLAG_BRANCH = 31;
  localparam int FLAG_ZERO   = 30;

  typedef struct packed {
    logic [31:0] flags;
    logic [31:0] alu;
    logic [31:0] instr;
    logic [31:0] pc;
  } rec_t;

  function automatic logic [31:0] pack_flags(input logic       branch,
                                             input logic       zero,
                                             input logic [4:0] dest);
    logic [31:0] w;
    w              = '0;
    w[FLAG_BRANCH] = branch;
    w[FLAG_ZERO]   = zero;
    w[4:0]         = dest;
    return w;
  endfunction

endpackage

// File: rtl/trace_rec_fifo.sv
// Synchronous FIFO of 128-bit trace records.
//   globalclock/globalreset : clock, async active-high reset
//   push, push_rec          : write request and record
//   pop                     : remove head record (ignored when empty)
//   head_rec                : record at the head (valid when !empty)
//   full, empty, count      : occupancy, count runs 0..DEPTH inclusive
// A push while full is accepted only if a pop frees the slot the same cycle.
module trace_rec_fifo
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic   globalclock,
  input  logic   globalreset,
  input  logic   push,
  input  rec_t   push_rec,
  input  logic   pop,
  output rec_t   head_rec,
  output logic   full,
  output logic   empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  rec_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_rec = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge globalclock or posedge globalreset) begin
    if (globalreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the reset
  // pointers/count, so stale entries are never observed.
  always_ff @(posedge globalclock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_rec;
  end

endmodule

// File: rtl/cpu_trace_capture.sv
// Captures per-cycle commit records from myCirc_cpu and streams them out.
//   globalclock/globalreset : clock, async active-high reset
//   arm, trig_pc, abort      : capture control (arm latches trig_pc)
//   pc_in .. zero_in         : CPU debug outputs sampled on each capture
//   trace_valid/ready/word/last : 32-bit word stream, 4 words per record
//   state, fifo_count, dropped  : FSM state, records held, saturating drops
module cpu_trace_capture
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int MAX_RECORDS = 16,
  parameter int CNT_W       = 16
) (
  input  logic                     globalclock,
  input  logic                     globalreset,
  input  logic                     arm,
  input  logic [31:0]              trig_pc,
  input  logic                     abort,
  input  logic [31:0]              pc_in,
  input  logic [31:0]              instr_in,
  input  logic [31:0]              alu_in,
  input  logic [4:0]               dest_in,
  input  logic                     branch_in,
  input  logic                     zero_in,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_word,
  output logic                     trace_last,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_RECORDS);

  state_e           state_q, state_d;
  logic [31:0]      trig_q, trig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] dropped_q, dropped_d;
  logic [1:0]       idx_q, idx_d;
  logic             capture, drop, word_xfer, pop;
  logic             fifo_full, fifo_empty;
  logic [AW:0]      fifo_cnt;
  rec_t             cap_rec, head_rec;

  assign cnt_inc = cnt_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    trig_d  = trig_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d = ST_ARMED;
            trig_d  = trig_pc;
            cnt_d   = '0;
          end
        end
        ST_ARMED: capture = (pc_in == trig_q);
        ST_RUN:   capture = 1'b1;
        default:  state_d = ST_IDLE;
      endcase
      // A dropped record still counts, so the limit depends only on captures.
      if (capture) begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == MAX_C) ? ST_DONE : ST_RUN;
      end
    end
  end

  always_ff @(posedge globalclock or posedge globalreset) begin
    if (globalreset) begin
      state_q   <= ST_IDLE;
      trig_q    <= '0;
      cnt_q     <= '0;
      dropped_q <= '0;
      idx_q     <= W_PC;
    end else begin
      state_q   <= state_d;
      trig_q    <= trig_d;
      cnt_q     <= cnt_d;
      dropped_q <= dropped_d;
      idx_q     <= idx_d;
    end
  end

  assign cap_rec = '{flags: pack_flags(branch_in, zero_in, dest_in),
                     alu:   alu_in,
                     instr: instr_in,
                     pc:    pc_in};

  // Popping the final word frees a slot in the same cycle, so a capture that
  // coincides with it is not a drop.
  assign word_xfer = trace_valid && trace_ready;
  assign pop       = word_xfer && (idx_q == W_FLAGS);
  assign drop      = capture && fifo_full && !pop;
  assign idx_d     = word_xfer ? idx_q + 1'b1 : idx_q;
  assign dropped_d = (drop && (dropped_q != '1)) ? dropped_q + 1'b1 : dropped_q;

  trace_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .globalclock (globalclock),
    .globalreset (globalreset),
    .push        (capture),
    .push_rec    (cap_rec),
    .pop         (pop),
    .head_rec    (head_rec),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_cnt)
  );

  // Word mux is forced to zero when empty so unwritten storage never shows.
  always_comb begin
    trace_word = '0;
    if (!fifo_empty) begin
      case (idx_q)
        W_PC:    trace_word = head_rec.pc;
        W_INSTR: trace_word = head_rec.instr;
        W_ALU:   trace_word = head_rec.alu;
        default: trace_word = head_rec.flags;
      endcase
    end
  end

  assign trace_valid = !fifo_empty;
  assign trace_last  = (idx_q == W_FLAGS);
  assign state       = state_q;
  assign fifo_count  = fifo_cnt;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Scoreboard bench for cpu_trace_capture: the stimulus thread queues the four
// expected words of every record that should reach the FIFO; an independent
// monitor pops and compares on every accepted word.
module tb_cpu_trace_capture;

  logic        globalclock = 1'b0;
  logic        globalreset;
  logic        arm, abort, trace_ready;
  logic [31:0] trig_pc, pc_in, instr_in, alu_in;
  logic [4:0]  dest_in;
  logic        branch_in, zero_in;
  logic        trace_valid, trace_last;
  logic [31:0] trace_word;
  logic [1:0]  state;
  logic [3:0]  fifo_count;
  logic [15:0] dropped;

  cpu_trace_capture #(.DEPTH(8), .MAX_RECORDS(16), .CNT_W(16)) dut (
    .globalclock (globalclock),
    .globalreset (globalreset),
    .arm         (arm),
    .trig_pc     (trig_pc),
    .abort       (abort),
    .pc_in       (pc_in),
    .instr_in    (instr_in),
    .alu_in      (alu_in),
    .dest_in     (dest_in),
    .branch_in   (branch_in),
    .zero_in     (zero_in),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_word  (trace_word),
    .trace_last  (trace_last),
    .state       (state),
    .fifo_count  (fifo_count),
    .dropped     (dropped)
  );

  always #5 globalclock = ~globalclock;

  typedef struct {
    logic [31:0] word;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          words_seen = 0;
  int          lasts_seen = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_word;
  logic        prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CPU debug outputs derived from the PC so every record is distinct.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA000_0000;
  endfunction
  function automatic logic [31:0] alu_of(input logic [31:0] pc);
    return pc * 3 + 1;
  endfunction
  function automatic logic [31:0] flags_of(input logic [31:0] pc);
    return {pc[2], pc[3], 25'b0, pc[6:2]};
  endfunction

  task automatic set_cpu(input logic [31:0] pc);
    pc_in     = pc;
    instr_in  = instr_of(pc);
    alu_in    = alu_of(pc);
    dest_in   = pc[6:2];
    branch_in = pc[2];
    zero_in   = pc[3];
  endtask

  task automatic expect_rec(input logic [31:0] pc);
    exp_q.push_back('{pc,           1'b0});
    exp_q.push_back('{instr_of(pc), 1'b0});
    exp_q.push_back('{alu_of(pc),   1'b0});
    exp_q.push_back('{flags_of(pc), 1'b1});
  endtask

  task automatic tick();
    @(posedge globalclock);
    #1;
  endtask

  task automatic drain(input bit rand_ready, input string tag);
    int n = 0;
    set_cpu(32'hFFFF_0000);
    while ((exp_q.size() != 0 || trace_valid) && n < 400) begin
      trace_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid"}, trace_valid, 1'b0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge globalclock) begin
    if (globalreset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && trace_valid) begin
        check("stable_word", trace_word, prev_word);
        check("stable_last", trace_last, prev_last);
      end
      if (trace_valid && trace_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %h, required no word", trace_word);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word", trace_word, e.word);
          check("last", trace_last, e.last);
          words_seen++;
          if (trace_last) lasts_seen++;
        end
      end
      prev_hold = trace_valid && !trace_ready;
      prev_word = trace_word;
      prev_last = trace_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    globalreset = 1'b1;
    arm = 0; abort = 0; trace_ready = 0; trig_pc = '0;
    set_cpu(32'h0);
    #1;
    check("rst_state", state, 2'd0);
    check("rst_valid", trace_valid, 1'b0);
    check("rst_word", trace_word, 32'h0);
    check("rst_last", trace_last, 1'b0);
    check("rst_count", fifo_count, 4'd0);
    check("rst_dropped", dropped, 16'd0);
    #11 globalreset = 1'b0;

    // Tests 1+2: trigger at 0x8, sink stalled; 8 kept, 8 dropped, DONE at 0x44.
    arm = 1; trig_pc = 32'h8; set_cpu(32'h0); tick();
    arm = 0;
    check("t1_armed", state, 2'd1);
    set_cpu(32'h4); tick();
    check("t1_still_armed", state, 2'd1);
    for (int k = 0; k < 16; k++) begin
      set_cpu(32'h8 + 32'(4 * k));
      if (k < 8) expect_rec(32'h8 + 32'(4 * k));
      tick();
      if (k == 0)  check("t1_run", state, 2'd2);
      if (k == 14) check("t1_run_before_last", state, 2'd2);
    end
    check("t1_done", state, 2'd3);
    check("t2_count_full", fifo_count, 4'd8);
    check("t2_dropped", dropped, 16'd8);
    check("t1_first_word", trace_word, 32'h0000_0008);
    words_seen = 0; lasts_seen = 0;
    drain(1'b0, "t2_drain");
    check("t2_words", 32'(words_seen), 32'd32);
    check("t2_lasts", 32'(lasts_seen), 32'd8);

    // Test 3: ready=1 throughout; FIFO fills at e9, r10/r11 dropped, r12
    // pushed alongside the word3 pop, then r13..r15 dropped.
    trace_ready = 1;
    arm = 1; trig_pc = 32'h100; set_cpu(32'hF0); tick();
    arm = 0;
    check("t3_armed", state, 2'd1);
    for (int k = 0; k < 16; k++) begin
      set_cpu(32'h100 + 32'(4 * k));
      if (!(k inside {10, 11, 13, 14, 15})) expect_rec(32'h100 + 32'(4 * k));
      tick();
      if (k == 9)  check("t3_full", fifo_count, 4'd8);
      if (k == 11) check("t3_dropped_pre", dropped, 16'd10);
      if (k == 12) begin
        check("t3_count_same_cycle", fifo_count, 4'd8);
        check("t3_dropped_same_cycle", dropped, 16'd10);
      end
    end
    check("t3_dropped_end", dropped, 16'd13);
    check("t3_done", state, 2'd3);
    drain(1'b0, "t3_drain");

    // Tests 4+5: random backpressure, abort+arm during RUN, FIFO drains.
    arm = 1; trig_pc = 32'h200; set_cpu(32'h1F0); tick();
    arm = 0;
    for (int k = 0; k < 6; k++) begin
      trace_ready = 1'($urandom_range(0, 1));
      set_cpu(32'h200 + 32'(4 * k));
      expect_rec(32'h200 + 32'(4 * k));
      tick();
      if (k == 0) check("t5_run", state, 2'd2);
    end
    abort = 1; arm = 1; trig_pc = 32'h999; set_cpu(32'h218); tick();
    abort = 0; arm = 0;
    check("t5_abort_idle", state, 2'd0);
    check("t5_dropped_kept", dropped, 16'd13);
    drain(1'b1, "t4_drain");
    arm = 1; trig_pc = 32'h400; set_cpu(32'h0); tick();
    arm = 0;
    check("t5_rearm", state, 2'd1);
    abort = 1; tick();
    abort = 0;
    check("t5_abort_armed", state, 2'd0);

    // Test 6: reset after word1 of a record is accepted.
    trace_ready = 0;
    arm = 1; trig_pc = 32'h300; set_cpu(32'h2FC); tick();
    arm = 0;
    set_cpu(32'h300); expect_rec(32'h300); tick();
    set_cpu(32'h304); expect_rec(32'h304); tick();
    abort = 1; set_cpu(32'h308); tick();
    abort = 0;
    check("t6_count", fifo_count, 4'd2);
    trace_ready = 1; tick(); tick();
    trace_ready = 0;
    check("t6_mid_record_word", trace_word, alu_of(32'h300));
    #2 globalreset = 1'b1;
    #1;
    check("t6_valid", trace_valid, 1'b0);
    check("t6_count_rst", fifo_count, 4'd0);
    check("t6_dropped_rst", dropped, 16'd0);
    check("t6_state_rst", state, 2'd0);
    check("t6_last_rst", trace_last, 1'b0);
    exp_q.delete();
    @(posedge globalclock);
    #2 globalreset = 1'b0;
    trace_ready = 1;
    repeat (8) tick();
    check("t6_no_reemit", trace_valid, 1'b0);
    check("t6_idle", state, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_trace_capture.md
Name: cpu_trace_capture

Overview:
- Consumes the per-cycle debug outputs of myCirc_cpu: PC, instruction, ALU result, destination register and branch/zero flags.
- Captures one commit record per clock, gated by an arm/trigger state machine, into a record FIFO.
- Streams records out as 32-bit words over a valid/ready handshake, for a bench checker or a later UART/JTAG dump path.

Parameters:
- DEPTH, 8, FIFO depth in records (power of two, >= 2).
- MAX_RECORDS, 16, records captured per trigger before stopping automatically (1..65535).
- CNT_W, 16, width of the drop and capture counters.

Ports:
- globalclock  in  1  system clock, rising edge.
- globalreset  in  1  asynchronous, active-high reset.
- arm  in  1  one-cycle pulse: IDLE or DONE -> ARMED; loads trig_pc.
- trig_pc  in  32  PC value that starts capture; sampled on arm.
- abort  in  1  forces IDLE from any state; the FIFO is kept.
- pc_in  in  32  CPU PC (_pcout).
- instr_in  in  32  CPU instruction (_Instruction).
- alu_in  in  32  CPU ALU result (_ALUresult).
- dest_in  in  5  CPU write-register index (_mux_out_regfiledest_5b).
- branch_in  in  1  CPU branch decision (_sel_branchornot).
- zero_in  in  1  CPU ALU zero flag (_isZero).
- trace_valid  out  1  a word is available.
- trace_ready  in  1  sink accepts the word.
- trace_word  out  32  current output word.
- trace_last  out  1  high on word 3 of a record.
- state  out  2  IDLE=0, ARMED=1, RUN=2, DONE=3.
- fifo_count  out  $clog2(DEPTH)+1  records currently held.
- dropped  out  CNT_W  saturating count of records lost to a full FIFO.

Behaviour:
- Reset (asynchronous): state=IDLE, FIFO empty, fifo_count=0, dropped=0, capture counter=0, word index=0, trace_valid=0, trace_word=0, trace_last=0. Reset mid-stream discards any partial record; no word is re-emitted after reset.
- IDLE: no capture. On arm -> ARMED and trig_pc is latched.
- ARMED: when pc_in == latched trig_pc -> RUN. The matching cycle is captured as record 0; the capture counter becomes 1.
- RUN: captures every cycle and increments the capture counter. When the counter reaches MAX_RECORDS (after that record is pushed) -> DONE.
- DONE: no capture. On arm -> ARMED; the counter clears and the FIFO is kept.
- abort wins over arm and over trigger in the same cycle: -> IDLE, counter cleared.
- arm while ARMED or RUN is ignored.
- Record layout:
  - word0 = pc_in
  - word1 = instr_in
  - word2 = alu_in
  - word3 = {branch_in, zero_in, 25'b0, dest_in}
- Capture samples all inputs on the rising edge. The record is written to the FIFO the same edge.
- Full FIFO: the new record is dropped and dropped increments, saturating at all-ones. A dropped record still counts toward MAX_RECORDS.
- Simultaneous push and final-word pop while full: the pop frees a slot in the same cycle, so the push is accepted with no drop.
- Output side:
  - trace_valid = (fifo_count != 0).
  - trace_word is selected combinationally from the head record by the word index.
  - trace_last = (index == 3).
  - A word transfers when trace_valid && trace_ready; the index then increments.
  - When word 3 transfers, the index wraps to 0 and the head record is popped.
- Stable-output rule: while trace_valid && !trace_ready, trace_word and trace_last stay stable.
- Latency: a record captured at edge N is visible as word0 after edge N (same-cycle valid is not allowed; registered FIFO).
- FIFO pointers are $clog2(DEPTH) bits with wrap-around. fifo_count tracks occupancy up to DEPTH inclusive.

Decomposition:
- Shared package cpu_trace_pkg:
  - state encoding localparams (ST_IDLE, ST_ARMED, ST_RUN, ST_DONE).
  - record word index constants (W_PC=0, W_INSTR=1, W_ALU=2, W_FLAGS=3).
  - flag bit positions (FLAG_BRANCH=31, FLAG_ZERO=30).
- One sub-module: trace_rec_fifo, a synchronous FIFO of 128-bit records. Its interface is push, pop, full, empty and count, with the same clock and reset names.
- The FSM, packing and word serializer live in cpu_trace_capture.

Test Plan:
1. Reset, arm with trig_pc=0x0000_0008; drive pc 0,4,8,12,... -> state goes ARMED then RUN on pc=0x8. First words out: 0x0000_0008, instr, alu, flags. MAX_RECORDS=16 -> DONE after pc=0x44.
2. trace_ready held 0 with DEPTH=8 during a 16-record run -> fifo_count=8, dropped=8. Then ready=1 -> exactly 32 words out, trace_last on every 4th word.
3. FIFO full, sink pops word3 in the same cycle the CPU pushes -> dropped unchanged, fifo_count stays 8.
4. Backpressure: toggle trace_ready randomly -> trace_word stable while valid && !ready. Word order per record is always pc, instr, alu, flags.
5. abort and arm in the same cycle during RUN -> state=IDLE, FIFO contents still drain. Then arm again -> ARMED.
6. Assert globalreset mid-record (after word1 accepted) -> trace_valid=0, fifo_count=0, dropped=0, state=IDLE immediately, without waiting for a clock edge.
